sextium_alu_seq: RTL

Sequential arithmetic unit that consumes the controller's aluinsn encoding and executes ADD/SUB/MUL/DIV on ACC (a) and DR (b). It sits downstream of the controller, replacing the purely combinational ALU feeding the accumulator mux (SELACC_ALU path). MUL and DIV are iterative: one bit per cycle, with a start/busy/done handshake so the controller can stall in a wait state.

---
 rtl/sextium_pkg.sv | 19 +
 rtl/sextium_muldiv_step.sv | 39 +++
 rtl/sextium_alu_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sextium_pkg.sv
// Shared Sextium III definitions: ALU op encoding (common with the controller's
// aluinsn field), sequential ALU state encoding and the default word width.
package sextium_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/sextium_muldiv_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or
// restoring shift-subtract divide, on WIDTH+1-bit values.
module sextium_muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH:0]   x_i,
    input  logic [WIDTH:0]   y_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH:0]   x_o,
    output logic [WIDTH:0]   y_o
);

    logic [WIDTH:0] trial;

    // MUL: acc=partial product, x=shifted multiplicand, y=multiplier (LSB first).
    // DIV: acc=partial remainder, x=divisor, y=dividend MSB out / quotient bits in.
    always_comb begin
        trial = {acc_i[WIDTH-1:0], y_i[WIDTH-1]};
        acc_o = acc_i;
        x_o   = x_i;
        y_o   = y_i;
        if (is_div) begin
            if (trial >= x_i) begin
                acc_o = trial - x_i;
                y_o   = {y_i[WIDTH-1:0], 1'b1};
            end else begin
                acc_o = trial;
                y_o   = {y_i[WIDTH-1:0], 1'b0};
            end
        end else begin
            acc_o = acc_i + (y_i[0] ? x_i : '0);
            x_o   = {x_i[WIDTH-1:0], 1'b0};
            y_o   = {1'b0, y_i[WIDTH:1]};
        end
    end

endmodule

// File: rtl/sextium_alu_seq.sv
// Sequential Sextium ALU: single-edge ADD/SUB, iterative signed MUL/DIV
// with a start/busy/done handshake for the controller's wait state.
module sextium_alu_seq
    import sextium_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
    logic [WIDTH:0]   acc_n, x_n, y_n;

    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - {1'b1, v}) : {1'b0, v};
    endfunction

    sextium_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_q == ALU_DIV),
        .acc_i  (acc_q),
        .x_i    (x_q),
        .y_i    (y_q),
        .acc_o  (acc_n),
        .x_o    (x_n),
        .y_o    (y_n)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        result_d = result_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                    dz_d = 1'b0;
                    if (op == ALU_ADD || op == ALU_SUB) begin
                        result_d = (op == ALU_ADD) ? a + b : a - b;
                        rem_d    = '0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        // Divide shifts the dividend through y; multiply walks the multiplier.
                        acc_d   = '0;
                        x_d     = (op == ALU_DIV) ? mag(b) : mag(a);
                        y_d     = (op == ALU_DIV) ? mag(a) : mag(b);
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                acc_d = acc_n;
                x_d   = x_n;
                y_d   = y_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                if (op_q == ALU_MUL) begin
                    result_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? '0 - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    rem_d    = '0;
                end else if (b_q == '0) begin
                    result_d = '0;
                    rem_d    = a_q;
                    dz_d     = 1'b1;
                end else begin
                    result_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? '0 - y_q[WIDTH-1:0] : y_q[WIDTH-1:0];
                    rem_d    = a_q[WIDTH-1] ? '0 - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            rem_q    <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule
